// File: rtl/compr_track.sv
// compr_track: two-stage pipelined unsigned/signed magnitude comparator with class-change
// detection and optional saturating per-class counters (enable with COMPR_TRACK_CNT_EN).
module compr_track #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   input  logic             clr_cnt,
   output logic             out_valid,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic             changed,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] lt_cnt
);

   typedef enum logic [1:0] {
      CLS_NONE = 2'd0,
      CLS_GT   = 2'd1,
      CLS_EQ   = 2'd2,
      CLS_LT   = 2'd3
   } cls_e;

   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             mode_r;
   logic             v1_r;
   cls_e             class_s;
   cls_e             last_class_r;

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   function automatic cls_e compare(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic sm);
      logic [WIDTH-1:0] xb;
      logic [WIDTH-1:0] yb;
      xb = x;
      yb = y;
      xb[WIDTH-1] = x[WIDTH-1] ^ sm;
      yb[WIDTH-1] = y[WIDTH-1] ^ sm;
      if (x == y) begin
         compare = CLS_EQ;
      end else if (xb > yb) begin
         compare = CLS_GT;
      end else begin
         compare = CLS_LT;
      end
   endfunction

   // Stage 1: capture the operand pair and its compare mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_r   <= 1'b0;
         a_r    <= {WIDTH{1'b0}};
         b_r    <= {WIDTH{1'b0}};
         mode_r <= 1'b0;
      end else begin
         v1_r <= in_valid;
         if (in_valid) begin
            a_r    <= a;
            b_r    <= b;
            mode_r <= signed_mode;
         end
      end
   end

   // Classify the captured pair.
   always_comb begin
      class_s = compare(a_r, b_r, mode_r);
   end

   // Stage 2: registered one-hot flags, change detection and last-class memory.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         gt           <= 1'b0;
         eq           <= 1'b0;
         lt           <= 1'b0;
         changed      <= 1'b0;
         last_class_r <= CLS_NONE;
      end else begin
         out_valid <= v1_r;
         gt        <= v1_r && (class_s == CLS_GT);
         eq        <= v1_r && (class_s == CLS_EQ);
         lt        <= v1_r && (class_s == CLS_LT);
         changed   <= v1_r && (last_class_r != CLS_NONE) && (class_s != last_class_r);
         if (v1_r) begin
            last_class_r <= class_s;
         end
      end
   end

`ifdef COMPR_TRACK_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] gt_cnt_r;
   logic [CNT_W-1:0] eq_cnt_r;
   logic [CNT_W-1:0] lt_cnt_r;

   // Counters follow the registered flags, so they lag out_valid by one cycle; clear wins.
   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         gt_cnt_r <= {CNT_W{1'b0}};
         eq_cnt_r <= {CNT_W{1'b0}};
         lt_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (gt && (gt_cnt_r != CNT_MAX)) begin
            gt_cnt_r <= gt_cnt_r + CNT_W'(1);
         end
         if (eq && (eq_cnt_r != CNT_MAX)) begin
            eq_cnt_r <= eq_cnt_r + CNT_W'(1);
         end
         if (lt && (lt_cnt_r != CNT_MAX)) begin
            lt_cnt_r <= lt_cnt_r + CNT_W'(1);
         end
      end
   end

   assign gt_cnt = gt_cnt_r;
   assign eq_cnt = eq_cnt_r;
   assign lt_cnt = lt_cnt_r;
`else
   logic unused_clr_s;

   assign unused_clr_s = clr_cnt;
   assign gt_cnt       = {CNT_W{1'b0}};
   assign eq_cnt       = {CNT_W{1'b0}};
   assign lt_cnt       = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_compr_track.sv
// Self-checking bench for compr_track: directed scenarios plus random traffic against
// a cycle-indexed behavioural model of classes, changes and counters.
module tb_compr_track;
   localparam int W  = 8;
   localparam int CW = 4;
`ifdef COMPR_TRACK_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [W-1:0]  a = 8'h00;
   logic [W-1:0]  b = 8'h00;
   logic          signed_mode = 1'b0;
   logic          clr_cnt = 1'b0;
   logic          out_valid, gt, eq, lt, changed;
   logic [CW-1:0] gt_cnt, eq_cnt, lt_cnt;

   int checks = 0;
   int errors = 0;

   // model state: 0 = none, 1 = gt, 2 = eq, 3 = lt
   int acc_prev = 0;
   int prev_out = 0;
   int last     = 0;
   int exp_out  = 0;
   int exp_chg  = 0;
   int cnt[3]   = '{0, 0, 0};

   compr_track #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
      .signed_mode(signed_mode), .clr_cnt(clr_cnt), .out_valid(out_valid),
      .gt(gt), .eq(eq), .lt(lt), .changed(changed),
      .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt)
   );

   always #5 clk = ~clk;

   function automatic int cls(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
      int vx;
      int vy;
      vx = int'(x);
      vy = int'(y);
      if (m && x[W-1]) vx = vx - (1 << W);
      if (m && y[W-1]) vy = vy - (1 << W);
      if (vx > vy) return 1;
      else if (vx == vy) return 2;
      else return 3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic iv, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                             input logic m, input logic clr, input logic r);
      int nout;
      nout = r ? 0 : acc_prev;
      for (int k = 0; k < 3; k++) begin
         if (!CNT_ON || r || clr) cnt[k] = 0;
         else if (prev_out == k + 1 && cnt[k] < (1 << CW) - 1) cnt[k] = cnt[k] + 1;
      end
      exp_chg = (nout != 0 && last != 0 && nout != last) ? 1 : 0;
      if (r) last = 0;
      else if (nout != 0) last = nout;
      acc_prev = (r || !iv) ? 0 : cls(ta, tb_v, m);
      prev_out = nout;
      exp_out  = nout;
   endtask

   task automatic step(input logic iv, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic m, input logic clr, input logic r);
      in_valid = iv; a = ta; b = tb_v; signed_mode = m; clr_cnt = clr; rst = r;
      @(posedge clk);
      model_edge(iv, ta, tb_v, m, clr, r);
      #1;
      chk("out_valid", 32'(out_valid), 32'(exp_out != 0));
      chk("gt", 32'(gt), 32'(exp_out == 1));
      chk("eq", 32'(eq), 32'(exp_out == 2));
      chk("lt", 32'(lt), 32'(exp_out == 3));
      chk("changed", 32'(changed), 32'(exp_chg));
      chk("gt_cnt", 32'(gt_cnt), 32'(cnt[0]));
      chk("eq_cnt", 32'(eq_cnt), 32'(cnt[1]));
      chk("lt_cnt", 32'(lt_cnt), 32'(cnt[2]));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      do_reset();
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_gt_cnt", 32'(gt_cnt), 32'd0);

      // 0x80 vs 0x7F unsigned then signed
      step(1'b1, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0);
      chk("dir_unsigned_gt", 32'(gt), 32'd1);
      chk("dir_first_no_change", 32'(changed), 32'd0);
      idle(1);
      chk("dir_signed_lt", 32'(lt), 32'd1);
      chk("dir_signed_changed", 32'(changed), 32'd1);
      idle(2);

      // three equal pairs after reset
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 8'h55, 8'h55, 1'b0, 1'b0, 1'b0);
      idle(2);
      chk("dir_eq_cnt3", 32'(eq_cnt), CNT_ON ? 32'd3 : 32'd0);

      // gt saturation at 15
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b1, 8'd200, 8'd1, 1'b0, 1'b0, 1'b0);
      idle(2);
      chk("dir_gt_sat", 32'(gt_cnt), CNT_ON ? 32'd15 : 32'd0);
      chk("dir_sat_lt_zero", 32'(lt_cnt), 32'd0);

      // clear coinciding with the sixth lt increment
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b1, 8'd1, 8'd9, 1'b0, 1'b0, 1'b0);
      idle(1);
      chk("dir_lt_cnt5", 32'(lt_cnt), CNT_ON ? 32'd5 : 32'd0);
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("dir_clr_wins", 32'(lt_cnt), 32'd0);
      step(1'b1, 8'hF0, 8'h10, 1'b1, 1'b0, 1'b0);
      idle(2);
      chk("dir_lt_after_clr", 32'(lt_cnt), CNT_ON ? 32'd1 : 32'd0);

      // reset right behind a valid pulse discards it
      do_reset();
      step(1'b1, 8'd7, 8'd3, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'd7, 8'd3, 1'b0, 1'b0, 1'b1);
      idle(3);
      chk("dir_rst_discard", 32'(out_valid), 32'd0);
      chk("dir_rst_cnt", 32'(gt_cnt), 32'd0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
         step($urandom_range(0, 3) != 0, ra, rb, 1'($urandom),
              $urandom_range(0, 15) == 0, $urandom_range(0, 49) == 0);
      end
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/compr_track.md
# compr_track

Parametrised, pipelined magnitude comparator that succeeds the 2-bit combinational comparator in the dataflow library. It accepts a stream of `a`/`b` operand pairs under a valid strobe and compares them as unsigned or signed. It returns registered one-hot `gt`/`eq`/`lt` flags two cycles later, flags class changes between consecutive results, and keeps saturating per-class occurrence counters. It is intended as the front-end check element in threshold monitors and self-checking benches.

## Interface

Parameters:
- `WIDTH`, 8: operand width in bits (≥1).
- `CNT_W`, 8: width of each occurrence counter (≥1).

Ports (clock is `clk`; reset is `rst`, synchronous, active-high):
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: synchronous active-high reset.
- `in_valid` input 1: operand pair valid this cycle.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `signed_mode` input 1: 1 = two's-complement compare, 0 = unsigned; sampled with `in_valid`.
- `clr_cnt` input 1: synchronous clear of all counters.
- `out_valid` output 1: result flags valid this cycle.
- `gt` output 1: A > B.
- `eq` output 1: A == B.
- `lt` output 1: A < B.
- `changed` output 1: result class differs from previous valid result.
- `gt_cnt` output CNT_W: count of gt results (saturating).
- `eq_cnt` output CNT_W: count of eq results (saturating).
- `lt_cnt` output CNT_W: count of lt results (saturating).

## Operation

- Stage 1 (capture): when `in_valid`=1, register `a`, `b`, `signed_mode` and set stage-1 valid. When `in_valid`=0, clear stage-1 valid; the operand registers hold.
- Stage 2 (compare): from stage-1 registers, compute the class and register `gt`/`eq`/`lt`. Set `out_valid` = stage-1 valid.
  - Signed compare interprets the MSB as sign.
  - `eq` is bitwise equality, independent of mode.
  - Operands are 2-state; no X propagation is required.
- Exactly one of `gt`/`eq`/`lt` is 1 when `out_valid`=1. All three are 0 when `out_valid`=0.
- Class state: a 2-bit `last_class` register (NONE, GT, EQ, LT) is updated on every valid result.
  - `changed`=1 with `out_valid` when the new class ≠ `last_class` and `last_class` ≠ NONE.
  - The first result after reset never asserts `changed`.
- Counters: on each valid result, the matching counter increments by 1. It saturates at 2^CNT_W−1 and does not wrap.
- `clr_cnt`=1 zeroes all three counters on the next edge. When it coincides with an increment, the clear wins and the counter is 0. `clr_cnt` does not affect `last_class` or the pipeline.
- No backpressure: one operand pair is accepted per cycle, with full throughput.

## Timing

- Latency: a pair presented with `in_valid` at edge N produces `out_valid` and flags at edge N+2. Counters reflect that result at edge N+3 (visible in the cycle after `out_valid`).
- Back-to-back `in_valid` produces back-to-back `out_valid` with no bubbles.
- Reset values: `out_valid`=0, `gt`=`eq`=`lt`=0, `changed`=0, all counters=0, `last_class`=NONE, stage-1 valid=0.
- Reset mid-operation: any pair in flight is discarded, and no `out_valid` is produced for it. `in_valid` is ignored in a cycle with `rst`=1.
- `signed_mode` may change on every pair; each pair uses the value sampled with it.

## Configuration

- `COMPR_TRACK_CNT_EN`
  - Defined: the three saturating counters and `clr_cnt` are implemented as above.
  - Not defined: the counter registers are not built; `gt_cnt`/`eq_cnt`/`lt_cnt` are tied to 0 and `clr_cnt` is ignored. Flags, `changed` and latency are unchanged.

## Test plan

- WIDTH=8, `a`=8'h80, `b`=8'h7F:
  - `signed_mode`=0 → `gt`=1 at N+2.
  - Same pair with `signed_mode`=1 on the next cycle → `lt`=1 at N+3, `changed`=1.
- `a`=`b`=8'h55 for 3 consecutive cycles after reset → `eq`=1 for 3 cycles, `changed`=0 throughout, `eq_cnt`=3.
- CNT_W=4, 20 consecutive pairs with `gt` class → `gt_cnt` reaches 15 and holds; `eq_cnt`=`lt_cnt`=0.
- `clr_cnt`=1 in the same cycle a `lt` result increments `lt_cnt` from 5 → `lt_cnt`=0 next cycle; the following `lt` result gives 1.
- `in_valid` pulse at edge N, `rst`=1 at edge N+1 → `out_valid` stays 0 through N+4; all counters stay 0.
- Build without `COMPR_TRACK_CNT_EN`, with 10 mixed pairs → flags and latency identical to the counter build; all counters read 0.
